// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types for the unified memory port arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Default byte-enable width for the 32-bit configuration
  localparam int BE_W = 32 / 8;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Which requester owns the current transaction
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/arb_perf_counters.sv
// ============================================================================
// Module   : arb_perf_counters
// Brief    : Three wrapping 32-bit event counters (fetch grants, data grants,
//            stall cycles). Only instantiated when ARB_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_if,
  input  logic        inc_d,
  input  logic        inc_stall,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_stall_cycles
);

  logic [31:0] if_cnt_q, if_cnt_d;
  logic [31:0] d_cnt_q, d_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Next counter values; wrap naturally on overflow
  always_comb begin
    if_cnt_d    = if_cnt_q + {31'd0, inc_if};
    d_cnt_d     = d_cnt_q + {31'd0, inc_d};
    stall_cnt_d = stall_cnt_q + {31'd0, inc_stall};
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      if_cnt_q    <= '0;
      d_cnt_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      if_cnt_q    <= if_cnt_d;
      d_cnt_q     <= d_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_if_grants    = if_cnt_q;
  assign perf_d_grants     = d_cnt_q;
  assign perf_stall_cycles = stall_cnt_q;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and MEM-stage
//            data accesses, one outstanding transaction at a time. Data has
//            priority, except that fetch is forced after MAX_D_STREAK
//            consecutive data grants while fetch waits.
//            Optional macro ARB_PERF_CNT_EN adds grant/stall perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]         perf_if_grants,
  output logic [31:0]         perf_d_grants,
  output logic [31:0]         perf_stall_cycles,
`endif
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_fetch,
  output logic                stall_mem
);

  localparam int               SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t              state_q, state_d;
  owner_t                  owner_q, owner_d;
  logic                    kill_q, kill_d;
  logic [SW-1:0]           streak_q, streak_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [DATA_W/8-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    if_done_q, if_done_d;
  logic                    d_done_q, d_done_d;
  logic [DATA_W-1:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]       d_rdata_q, d_rdata_d;

  logic                    fetch_ok;
  logic                    force_if;
  logic                    grant_d;
  logic                    grant_if;
  logic                    kill_now;
  logic                    deliver;

  // Arbitration: data first, unless the streak limit forces a fetch grant.
  // A flush in IDLE removes fetch from contention for that cycle.
  assign fetch_ok = if_req & ~if_flush;
  assign force_if = fetch_ok & (streak_q == STREAK_MAX);
  assign grant_d  = (state_q == IDLE) & d_req & ~force_if;
  assign grant_if = (state_q == IDLE) & fetch_ok & ~grant_d;

  // The owner has abandoned the transaction (flush or dropped request)
  assign kill_now = (owner_q == OWN_IF) ? (if_flush | ~if_req) : ~d_req;
  assign deliver  = (state_q == WAIT) & mem_rvalid & ~kill_q & ~kill_now;

  // State register plus all datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      kill_q      <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state logic of the transaction sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_if | grant_d) state_d = REQ;
      REQ:     if (mem_ready)          state_d = WAIT;
      WAIT:    if (mem_rvalid)         state_d = RESP;
      RESP:                            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Grant latching, kill tracking, streak counting and response capture
  always_comb begin
    owner_d     = owner_q;
    kill_d      = kill_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    if (grant_d) begin
      owner_d     = OWN_D;
      kill_d      = 1'b0;
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_be_d    = d_be;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      if (if_req && (streak_q != STREAK_MAX)) streak_d = streak_q + 1'b1;
    end else if (grant_if) begin
      owner_d     = OWN_IF;
      kill_d      = 1'b0;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_be_d    = '1;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      streak_d    = '0;
    end

    if ((state_q == REQ) && mem_ready) mem_req_d = 1'b0;

    // Once abandoned, a transaction drains without a completion pulse
    if (((state_q == REQ) || (state_q == WAIT)) && kill_now) kill_d = 1'b1;

    if (deliver) begin
      if (owner_q == OWN_IF) begin
        if_done_d  = 1'b1;
        if_rdata_d = mem_rdata;
      end else begin
        d_done_d = 1'b1;
        if (!mem_we_q) d_rdata_d = mem_rdata;
      end
    end

    // Streak only accumulates while fetch is actually waiting
    if (!if_req) streak_d = '0;
  end

  // Output drive; a flush during RESP still suppresses the fetch pulse
  assign if_done     = if_done_q & ~if_flush;
  assign d_done      = d_done_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign stall_fetch = if_req & ~if_done & ~if_flush;
  assign stall_mem   = d_req & ~d_done;

`ifdef ARB_PERF_CNT_EN
  arb_perf_counters u_perf (
    .clk               (clk),
    .rst               (rst),
    .inc_if            (grant_if),
    .inc_d             (grant_d),
    .inc_stall         (stall_fetch | stall_mem),
    .perf_if_grants    (perf_if_grants),
    .perf_d_grants     (perf_d_grants),
    .perf_stall_cycles (perf_stall_cycles)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_done;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_fetch, stall_mem;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_stall_cycles;
`endif

  // Memory responder: automatic (ready=1, rvalid one cycle after accept)
  // or manually driven by the directed steps
  logic        auto_mem;
  logic        a_rvalid;
  logic [31:0] a_rdata;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;

  assign mem_ready  = auto_mem ? 1'b1 : m_ready;
  assign mem_rvalid = auto_mem ? a_rvalid : m_rvalid;
  assign mem_rdata  = auto_mem ? a_rdata : m_rdata;

  always @(posedge clk) begin
    a_rvalid <= mem_req & mem_ready;
    a_rdata  <= mem_addr ^ 32'hC0DE_0000;
  end

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter dut (
`ifdef ARB_PERF_CNT_EN
    .perf_if_grants    (perf_if_grants),
    .perf_d_grants     (perf_d_grants),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_flush    (if_flush),
    .if_rdata    (if_rdata),
    .if_done     (if_done),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_be        (d_be),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_done      (d_done),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .stall_fetch (stall_fetch),
    .stall_mem   (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts cycles (request cycle = 0) until the selected done pulse; -1 on timeout
  task automatic wait_pulse(input bit want_if, output int cyc);
    cyc = -1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      #1;
      if ((want_if ? if_done : d_done) === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  int          cyc;
  int          d_at, if_at, stall_low, bad;
  int          g;
  logic [31:0] grants [6];

  initial begin
    rst = 1'b1; auto_mem = 1'b1;
    if_req = 0; if_addr = 0; if_flush = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    m_ready = 0; m_rvalid = 0; m_rdata = 0;
    repeat (3) tick();
    #1;
    check("rst_mem_req",  mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_done",     {if_done, d_done}, 0);
    check("rst_rdata",    {if_rdata, d_rdata}, 0);
    check("rst_stalls",   {stall_fetch, stall_mem}, 0);
    rst = 1'b0;
    tick();

    // ---- Fetch only, minimum latency ----
    if_req = 1; if_addr = 32'h100; #1;
    check("t1_stall_n", stall_fetch, 1);
    check("t1_memreq_n", mem_req, 0);
    tick();
    check("t1_memreq_n1", mem_req, 1);
    check("t1_memaddr", mem_addr, 32'h100);
    check("t1_memwe", mem_we, 0);
    tick();
    check("t1_done_n2", if_done, 0);
    tick();
    check("t1_done_n3", if_done, 1);
    check("t1_rdata", if_rdata, 32'hC0DE_0100);
    check("t1_stall_n3", stall_fetch, 0);
    if_req = 0;
    tick();
    check("t1_done_n4", if_done, 0);

    // ---- Simultaneous requests: data first, fetch after ----
    if_req = 1; if_addr = 32'h100;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h2000;
    d_at = -1; if_at = -1; stall_low = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      if (d_at >= 0) d_req = 0;
      #1;
      if (d_done === 1'b1) d_at = c;
      if (if_done === 1'b1) begin
        if_at = c;
        break;
      end
      if (stall_fetch !== 1'b1) stall_low++;
    end
    check("t2_d_done_cyc", d_at, 3);
    check("t2_if_done_cyc", if_at, 7);
    check("t2_stall_low", stall_low, 0);
    check("t2_d_rdata", d_rdata, 32'hC0DE_2000);
    if_req = 0; d_req = 0;
    tick(); tick();

    // ---- Streak limit: 4 data grants, 1 fetch, then data ----
    if_req = 1; if_addr = 32'h400;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h3000;
    g = 0;
    for (int i = 0; i < 6; i++) grants[i] = 32'h0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) tick();
      #1;
      if (mem_req === 1'b1 && mem_ready === 1'b1) begin
        grants[g] = mem_addr;
        g++;
        if (g == 6) break;
      end
    end
    check("t3_grant0", grants[0], 32'h3000);
    check("t3_grant1", grants[1], 32'h3000);
    check("t3_grant2", grants[2], 32'h3000);
    check("t3_grant3", grants[3], 32'h3000);
    check("t3_grant4", grants[4], 32'h400);
    check("t3_grant5", grants[5], 32'h3000);
    if_req = 0; d_req = 0;
    repeat (8) tick();

    // ---- Flush while fetch in WAIT ----
    auto_mem = 0; m_ready = 1; m_rvalid = 0;
    tick();
    if_req = 1; if_addr = 32'h500;
    tick();
    check("t4_memreq", mem_req, 1);
    check("t4_memaddr", mem_addr, 32'h500);
    tick();
    m_ready = 0; if_flush = 1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h2400;
    #1;
    check("t4_stall_flush", stall_fetch, 0);
    check("t4_stall_mem", stall_mem, 1);
    tick();
    if_flush = 0; if_req = 0; #1;
    check("t4_stall_after", stall_fetch, 0);
    check("t4_no_grant_a", mem_req, 0);
    tick();
    m_rvalid = 1; m_rdata = 32'hBAD0_BAD0; #1;
    check("t4_no_done_a", if_done, 0);
    tick();
    m_rvalid = 0; #1;
    check("t4_no_done_b", if_done, 0);
    check("t4_no_grant_b", mem_req, 0);
    tick();
    check("t4_no_grant_c", mem_req, 0);
    tick();
    check("t4_d_granted", mem_req, 1);
    check("t4_d_addr", mem_addr, 32'h2400);
    auto_mem = 1;
    wait_pulse(1'b0, cyc);
    check("t4_d_done_cyc", cyc, 2);
    check("t4_d_rdata", d_rdata, 32'hC0DE_2400);
    tick();
    d_req = 0;
    tick();

    // ---- Store with mem_ready delayed 3 cycles ----
    auto_mem = 0; m_ready = 0; m_rvalid = 0;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2800; d_wdata = 32'hDEAD_BEEF;
    bad = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (!(mem_req === 1'b1 && mem_we === 1'b1 && mem_be === 4'b0011 &&
            mem_addr === 32'h2800 && mem_wdata === 32'hDEAD_BEEF)) bad++;
    end
    check("t5_fields_stable", bad, 0);
    tick();
    m_ready = 1; #1;
    check("t5_memreq_held", mem_req, 1);
    tick();
    m_ready = 0; m_rvalid = 1; #1;
    check("t5_no_early_done", d_done, 0);
    tick();
    m_rvalid = 0; #1;
    check("t5_d_done", d_done, 1);
    check("t5_d_rdata_held", d_rdata, 32'hC0DE_2400);
    tick();
    d_req = 0; d_we = 0; #1;
    check("t5_d_done_once", d_done, 0);
    check("t5_memreq_idle", mem_req, 0);

    // ---- Reset in WAIT followed by a stray response ----
    tick();
    m_ready = 1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h2C00;
    tick();
    check("t6_memreq", mem_req, 1);
    tick();
    rst = 1; d_req = 0; m_ready = 0;
    tick();
    rst = 0; m_rvalid = 1; m_rdata = 32'h1234_5678; #1;
    check("t6_rst_memreq", mem_req, 0);
    check("t6_rst_memaddr", mem_addr, 0);
    check("t6_rst_rdata", {if_rdata, d_rdata}, 0);
    check("t6_rst_done", {if_done, d_done}, 0);
    tick();
    m_rvalid = 0; #1;
    check("t6_stray_done", {if_done, d_done}, 0);
    check("t6_stray_memreq", mem_req, 0);
    auto_mem = 1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h3000;
    wait_pulse(1'b0, cyc);
    check("t6_next_done_cyc", cyc, 3);
    check("t6_next_rdata", d_rdata, 32'hC0DE_3000);
    tick();
    d_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
